// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: synchronizes a raw asynchronous input, debounces it, and emits edge pulses.
// Latency: a din change appears on dout/rise/fall SYNC_STAGES + DEBOUNCE_CYCLES enabled edges later.
// Backpressure: none; en only gates qualification (the synchronizer always shifts).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   en     - sample enable/tick (tie high for per-clock sampling)
//   din    - raw asynchronous input
//   dout   - debounced, registered level
//   rise   - one-cycle pulse in the cycle dout goes 0->1
//   fall   - one-cycle pulse in the cycle dout goes 1->0
//   busy   - high while a qualification is in progress
//   glitch - one-cycle pulse when a qualification aborts
//
// Optional feature macro: DEBOUNCE_GLITCH_FLAG_EN
//   defined   -> glitch is a registered abort pulse
//   undefined -> glitch is tied to 0 and no abort-flag logic exists

module debounce_edge_detect #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy,
  output logic glitch
);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  // Terminal count: the sample that reaches this value is the last one
  // needed to accept the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       count;

  // Synchronizer chain: shifts every edge regardless of en so that the
  // metastability-settling time never depends on the sample tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Qualification FSM. count holds the number of consecutive enabled
  // samples that have disagreed with dout so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE;
      count <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          STABLE: begin
            if (s != dout) begin
              if (DEBOUNCE_CYCLES == 1) begin
                // A single disagreeing sample is enough: flip right away.
                dout <= s;
                rise <= s;
                fall <= ~s;
              end else begin
                count <= CNT_W'(1);
                state <= COUNTING;
              end
            end
          end
          COUNTING: begin
            if (s == dout) begin
              // Input fell back before qualifying: abandon the attempt.
              count <= '0;
              state <= STABLE;
            end else if (count == CNT_LAST) begin
              dout  <= ~dout;
              rise  <= ~dout;
              fall  <= dout;
              count <= '0;
              state <= STABLE;
            end else begin
              count <= count + 1'b1;
            end
          end
          default: begin
            count <= '0;
            state <= STABLE;
          end
        endcase
      end
    end
  end

  assign busy = (state == COUNTING);

`ifdef DEBOUNCE_GLITCH_FLAG_EN
  // Abort flag: same condition as the COUNTING -> STABLE abort above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch <= 1'b0;
    end else begin
      glitch <= en && (state == COUNTING) && (s == dout);
    end
  end
`else
  assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect: directed and randomized checks of debounce_edge_detect.
// Latency: expectations are taken one half-cycle after each rising edge.
// Backpressure: not applicable; the bench drives en and din freely.

module tb_debounce_edge_detect;

  localparam int SYNC = 2;
  localparam int DC   = 4;
`ifdef DEBOUNCE_GLITCH_FLAG_EN
  localparam bit GLITCH_ON = 1'b1;
`else
  localparam bit GLITCH_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic en;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;
  logic glitch;

  int checks   = 0;
  int failures = 0;

  debounce_edge_detect #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy),
    .glitch(glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: s is simply the din value captured SYNC edges earlier
  // (0 if that edge predates reset release); run is the length of the
  // current streak of enabled samples that disagree with dout.
  bit          din_log [0:63];
  int          m_n;
  int          m_run;
  logic        m_dout;
  logic        m_rise;
  logic        m_fall;
  logic        m_glitch;

  always @(posedge clk or posedge reset) begin : ref_model
    bit s;
    int r;
    if (reset) begin
      m_n      <= 0;
      m_run    <= 0;
      m_dout   <= 1'b0;
      m_rise   <= 1'b0;
      m_fall   <= 1'b0;
      m_glitch <= 1'b0;
    end else begin
      s = (m_n >= SYNC) ? din_log[(m_n - SYNC) % 64] : 1'b0;
      r = m_run;
      m_rise   <= 1'b0;
      m_fall   <= 1'b0;
      m_glitch <= 1'b0;
      if (en) begin
        if (s != m_dout) begin
          r = r + 1;
          if (r == DC) begin
            m_dout <= s;
            m_rise <= s;
            m_fall <= !s;
            r = 0;
          end
        end else begin
          m_glitch <= GLITCH_ON && (r != 0);
          r = 0;
        end
      end
      din_log[m_n % 64] <= din;
      m_n   <= m_n + 1;
      m_run <= r;
    end
  end

  logic [4:0] obs;
  logic [4:0] mdl;
  assign obs = {dout, rise, fall, busy, glitch};
  assign mdl = {m_dout, m_rise, m_fall, (m_run != 0), m_glitch};

  // Drive din to a level with en high long enough for dout to follow.
  task automatic settle(input logic lvl);
    en  = 1'b1;
    din = lvl;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    en = 1'b1; din = 1'b1; reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("FAIL reset_hold: {dout,rise,fall,busy,glitch} got %b want 00000", obs);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (rise !== (k == 6)) begin
        failures++;
        $display("FAIL reset_rise edge %0d: got %b want %b", k, rise, (k == 6));
      end
      checks++;
      if (dout !== (k >= 6)) begin
        failures++;
        $display("FAIL reset_dout edge %0d: got %b want %b", k, dout, (k >= 6));
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL reset_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
  endtask

  task automatic test_fall();
    settle(1'b1);
    checks++;
    if (dout !== 1'b1) begin
      failures++;
      $display("FAIL fall_start: dout got %b want 1", dout);
    end
    din = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({dout, rise, fall} !== {(k < 6), 1'b0, (k == 6)}) begin
        failures++;
        $display("FAIL fall_edge %0d: {dout,rise,fall} got %b want %b",
                 k, {dout, rise, fall}, {(k < 6), 1'b0, (k == 6)});
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL fall_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
  endtask

  task automatic test_rise();
    settle(1'b0);
    checks++;
    if (dout !== 1'b0) begin
      failures++;
      $display("FAIL rise_start: dout got %b want 0", dout);
    end
    din = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({dout, rise, fall, busy} !== {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)}) begin
        failures++;
        $display("FAIL rise_edge %0d: {dout,rise,fall,busy} got %b want %b",
                 k, {dout, rise, fall, busy}, {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)});
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL rise_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
  endtask

  task automatic test_glitch();
    settle(1'b0);
    din = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) din = 1'b0;
      checks++;
      if ({dout, rise, busy, glitch} !== {1'b0, 1'b0, (k == 3 || k == 4), GLITCH_ON && (k == 5)}) begin
        failures++;
        $display("FAIL glitch_edge %0d: {dout,rise,busy,glitch} got %b want %b",
                 k, {dout, rise, busy, glitch}, {1'b0, 1'b0, (k == 3 || k == 4), GLITCH_ON && (k == 5)});
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL glitch_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
  endtask

  task automatic test_en_toggle();
    settle(1'b0);
    din = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      en = ~en;
      checks++;
      if ({dout, rise, busy} !== {(k >= 9), (k == 9), (k >= 3 && k <= 8)}) begin
        failures++;
        $display("FAIL en_toggle_edge %0d: {dout,rise,busy} got %b want %b",
                 k, {dout, rise, busy}, {(k >= 9), (k == 9), (k >= 3 && k <= 8)});
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL en_toggle_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_toggling_din();
    settle(1'b0);
    for (int k = 1; k <= 20; k++) begin
      din = ~din;
      @(negedge clk);
      checks++;
      if ({dout, rise, fall} !== 3'b000) begin
        failures++;
        $display("FAIL toggle_din edge %0d: {dout,rise,fall} got %b want 000", k, {dout, rise, fall});
      end
    end
  endtask

  task automatic test_reset_midcount();
    settle(1'b0);
    din = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midcount_busy: got %b want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dout, busy, rise, fall} !== 4'b0000) begin
      failures++;
      $display("FAIL midcount_async_clear: {dout,busy,rise,fall} got %b want 0000", {dout, busy, rise, fall});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({dout, rise} !== {(k >= 6), (k == 6)}) begin
        failures++;
        $display("FAIL midcount_requal edge %0d: {dout,rise} got %b want %b",
                 k, {dout, rise}, {(k >= 6), (k == 6)});
      end
      checks++;
      if (obs !== mdl) begin
        failures++;
        $display("FAIL midcount_model edge %0d: got %b want %b", k, obs, mdl);
      end
    end
  endtask

  task automatic test_random();
    logic prev_rise = 1'b0;
    logic prev_fall = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      din = 1'($urandom_range(0, 1));
      for (int c = $urandom_range(1, 8); c > 0; c--) begin
        en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        checks++;
        if (obs !== mdl) begin
          failures++;
          $display("FAIL random_model seg %0d: got %b want %b", seg, obs, mdl);
        end
        checks++;
        if ((rise & fall) !== 1'b0 || (rise & prev_rise) !== 1'b0 || (fall & prev_fall) !== 1'b0) begin
          failures++;
          $display("FAIL random_pulse_shape seg %0d: rise=%b fall=%b prev_rise=%b prev_fall=%b want no overlap/repeat",
                   seg, rise, fall, prev_rise, prev_fall);
        end
        prev_rise = rise;
        prev_fall = fall;
      end
    end
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    din   = 1'b1;
    test_reset();
    test_fall();
    test_rise();
    test_glitch();
    test_en_toggle();
    test_toggling_din();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
